// File: rtl/pix_delay_ctrl_if.sv
// pix_delay_ctrl_if: strobe/address bus between the delay-line controller
// and the external simple-dual-port RAM that holds the delayed pixels.
// The controller owns the bus (master); the RAM wrapper consumes it (slave).
interface pix_delay_ctrl_if #(
  parameter int ADDR_W = 6
);
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_raddr;

  modport master (
    output ram_we,
    output ram_waddr,
    output ram_re,
    output ram_raddr
  );

  modport slave (
    input ram_we,
    input ram_waddr,
    input ram_re,
    input ram_raddr
  );
endinterface

// File: rtl/pix_delay_ctrl.sv
// pix_delay_ctrl: sequences a RAM-based pixel delay line.
// A circular write pointer addresses the external RAM; the read address trails
// it by the programmed depth. The vs/hs/de qualifiers travel through a matching
// register chain so sync stays aligned with the RAM data. A new depth requested
// through cfg_wr is held as "pending" and only takes effect at the next frame
// start (rising i_vs on a pixel strobe), after which the line refills.
// Optional build macro: DELAY_BYPASS_EN adds i_bypass, which turns the line
// into a single-register pass-through and refills when bypass is released.
module pix_delay_ctrl #(
  parameter int ADDR_W    = 6,
  parameter int MAX_DEPTH = 64,
  parameter int DEF_DEPTH = 56
) (
  input  logic             pixelclk,
  input  logic             rst,
`ifdef DELAY_BYPASS_EN
  input  logic             i_bypass,
`endif
  input  logic             en,
  input  logic             i_vs,
  input  logic             i_hs,
  input  logic             i_de,
  input  logic [6:0]       cfg_depth,
  input  logic             cfg_wr,
  pix_delay_ctrl_if.master ram,
  output logic             o_vs,
  output logic             o_hs,
  output logic             o_de,
  output logic             o_valid,
  output logic             cfg_err,
  output logic             busy
);

  localparam int         TapW      = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam logic [6:0] MaxDepthC = 7'(MAX_DEPTH);
  localparam logic [6:0] DefDepthC = 7'(DEF_DEPTH);

  typedef enum logic {
    StFill = 1'b0,
    StRun  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [6:0]        depth_q, depth_d;
  logic [6:0]        pend_q;
  logic [6:0]        fillCnt_q, fillCnt_d;
  logic [ADDR_W-1:0] wrPtr_q;
  logic              vsPrev_q;
  logic              frameStart;
  logic              cfgIllegal;

  logic              ramWe_q;
  logic              ramRe_q;
  logic [ADDR_W-1:0] ramWaddr_q;
  logic [ADDR_W-1:0] ramRaddr_q;

  logic [2:0]        chain_q [MAX_DEPTH];
  logic [2:0]        oSync_q;
  logic              oValid_q;
  logic              cfgErr_q;
  logic              busy_q;
  logic [TapW-1:0]   tapIdx;

  logic              bypassOn;
  logic              bypassExit;

`ifdef DELAY_BYPASS_EN
  logic bypassPrev_q;

  // Remember last cycle's bypass so its release can be detected and force a refill.
  always_ff @(posedge pixelclk) begin
    if (rst) begin
      bypassPrev_q <= 1'b0;
    end else begin
      bypassPrev_q <= i_bypass;
    end
  end

  assign bypassOn   = i_bypass;
  assign bypassExit = bypassPrev_q & ~i_bypass;
`else
  assign bypassOn   = 1'b0;
  assign bypassExit = 1'b0;
`endif

  assign cfgIllegal = (cfg_depth == 7'd0) || (cfg_depth > MaxDepthC);
  assign tapIdx     = TapW'(depth_q - 7'd1);

  // Next-state logic: count fill strobes, then run; a frame start with a
  // different pending depth swaps the depth in and restarts the fill.
  always_comb begin
    state_d    = state_q;
    depth_d    = depth_q;
    fillCnt_d  = fillCnt_q;
    frameStart = en && i_vs && !vsPrev_q;

    if (en && (state_q == StFill)) begin
      fillCnt_d = fillCnt_q + 7'd1;
      if (fillCnt_q == depth_q - 7'd1) begin
        state_d = StRun;
      end
    end

    if (frameStart && (pend_q != depth_q)) begin
      depth_d   = pend_q;
      fillCnt_d = 7'd0;
      state_d   = StFill;
    end

    if (bypassExit) begin
      fillCnt_d = 7'd0;
      state_d   = StFill;
    end
  end

  // State, depth, fill counter, write pointer and the en-sampled vs history.
  always_ff @(posedge pixelclk) begin
    if (rst) begin
      state_q   <= StFill;
      depth_q   <= DefDepthC;
      fillCnt_q <= 7'd0;
      wrPtr_q   <= '0;
      vsPrev_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      depth_q   <= depth_d;
      fillCnt_q <= fillCnt_d;
      if (en) begin
        wrPtr_q  <= wrPtr_q + 1'b1;
        vsPrev_q <= i_vs;
      end
    end
  end

  // Pending depth capture; illegal requests are dropped and flagged for one cycle.
  always_ff @(posedge pixelclk) begin
    if (rst) begin
      pend_q   <= DefDepthC;
      cfgErr_q <= 1'b0;
    end else begin
      cfgErr_q <= cfg_wr && cfgIllegal;
      if (cfg_wr && !cfgIllegal) begin
        pend_q <= cfg_depth;
      end
    end
  end

  // Registered RAM strobes and addresses; read trails write by the current depth.
  always_ff @(posedge pixelclk) begin
    if (rst) begin
      ramWe_q    <= 1'b0;
      ramRe_q    <= 1'b0;
      ramWaddr_q <= '0;
      ramRaddr_q <= '0;
    end else begin
      ramWe_q <= en && !bypassOn;
      ramRe_q <= en && !bypassOn;
      if (en) begin
        ramWaddr_q <= wrPtr_q;
        ramRaddr_q <= wrPtr_q - ADDR_W'(depth_q);
      end
    end
  end

  // Sync/DE shift chain advanced on each strobe, cleared on reset.
  always_ff @(posedge pixelclk) begin
    if (rst) begin
      for (int i = 0; i < MAX_DEPTH; i++) begin
        chain_q[i] <= 3'b000;
      end
    end else if (en) begin
      chain_q[0] <= {i_vs, i_hs, i_de};
      for (int i = 1; i < MAX_DEPTH; i++) begin
        chain_q[i] <= chain_q[i-1];
      end
    end
  end

  // Output tap, valid flag and busy flag, all aligned with returning RAM data.
  always_ff @(posedge pixelclk) begin
    if (rst) begin
      oSync_q  <= 3'b000;
      oValid_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      busy_q   <= (state_q == StFill);
      oValid_q <= bypassOn ? en : (en && (state_q == StRun));
      if (en) begin
        oSync_q <= bypassOn ? {i_vs, i_hs, i_de} : chain_q[tapIdx];
      end
    end
  end

  assign ram.ram_we    = ramWe_q;
  assign ram.ram_re    = ramRe_q;
  assign ram.ram_waddr = ramWaddr_q;
  assign ram.ram_raddr = ramRaddr_q;

  assign o_vs    = oSync_q[2];
  assign o_hs    = oSync_q[1];
  assign o_de    = oSync_q[0];
  assign o_valid = oValid_q;
  assign cfg_err = cfgErr_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_pix_delay_ctrl.sv
// tb_pix_delay_ctrl: directed sequence with randomized pixel qualifiers,
// checked every cycle against a strobe-history model of the delay line.
module tb_pix_delay_ctrl;

  logic       pixelclk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       i_vs = 1'b0;
  logic       i_hs = 1'b0;
  logic       i_de = 1'b0;
  logic [6:0] cfg_depth = 7'd0;
  logic       cfg_wr = 1'b0;
  logic       o_vs, o_hs, o_de, o_valid, cfg_err, busy;

  pix_delay_ctrl_if #(.ADDR_W(6)) ramIf ();

  pix_delay_ctrl #(.ADDR_W(6), .MAX_DEPTH(64), .DEF_DEPTH(56)) dut (
    .pixelclk (pixelclk),
    .rst      (rst),
    .en       (en),
    .i_vs     (i_vs),
    .i_hs     (i_hs),
    .i_de     (i_de),
    .cfg_depth(cfg_depth),
    .cfg_wr   (cfg_wr),
    .ram      (ramIf.master),
    .o_vs     (o_vs),
    .o_hs     (o_hs),
    .o_de     (o_de),
    .o_valid  (o_valid),
    .cfg_err  (cfg_err),
    .busy     (busy)
  );

  always #5 pixelclk = ~pixelclk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: every strobe's qualifiers are kept in order; output after
  // strobe n is the entry from strobe n-depth (zero before enough history).
  logic [2:0] hist [$];
  int         strobes;
  int         mDepth;
  int         mPend;
  int         fillLeft;
  logic       prevVs;

  logic       expWe, expRe, expValid, expErr, expBusy;
  logic [5:0] expWaddr, expRaddr;
  logic [2:0] expSync;

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelStep(input logic r, input logic e, input logic [2:0] sync,
                           input logic cw, input logic [6:0] cd);
    int  idx;
    logic bad;
    if (r) begin
      expWe = 0; expRe = 0; expWaddr = 0; expRaddr = 0;
      expSync = 0; expValid = 0; expErr = 0; expBusy = 0;
      hist.delete();
      strobes = 0; mDepth = 56; mPend = 56; fillLeft = 56; prevVs = 0;
      return;
    end
    bad      = cw && ((cd == 0) || (cd > 64));
    expBusy  = (fillLeft != 0);
    expErr   = bad;
    expValid = e && (fillLeft == 0);
    expWe    = e;
    expRe    = e;
    if (e) begin
      expWaddr = 6'(strobes & 63);
      expRaddr = 6'((strobes - mDepth) & 63);
      idx      = strobes - mDepth;
      expSync  = (idx >= 0) ? hist[idx] : 3'b000;
      hist.push_back(sync);
      if (sync[2] && !prevVs && (mPend != mDepth)) begin
        mDepth   = mPend;
        fillLeft = mDepth;
      end else if (fillLeft > 0) begin
        fillLeft--;
      end
      prevVs = sync[2];
      strobes++;
    end
    if (cw && !bad) mPend = int'(cd);
  endtask

  task automatic checkOutput();
    checkOne("ram_we",    32'(ramIf.ram_we),    32'(expWe));
    checkOne("ram_re",    32'(ramIf.ram_re),    32'(expRe));
    checkOne("ram_waddr", 32'(ramIf.ram_waddr), 32'(expWaddr));
    checkOne("ram_raddr", 32'(ramIf.ram_raddr), 32'(expRaddr));
    checkOne("sync",      32'({o_vs, o_hs, o_de}), 32'(expSync));
    checkOne("o_valid",   32'(o_valid),         32'(expValid));
    checkOne("cfg_err",   32'(cfg_err),         32'(expErr));
    checkOne("busy",      32'(busy),            32'(expBusy));
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [2:0] sync,
                               input logic cw, input logic [6:0] cd);
    rst = r; en = e; {i_vs, i_hs, i_de} = sync; cfg_wr = cw; cfg_depth = cd;
    modelStep(r, e, sync, cw, cd);
    @(posedge pixelclk);
    #1;
    checkOutput();
  endtask

  function automatic logic [2:0] rndSync(input logic vs);
    logic [1:0] hd;
    hd = 2'($urandom);
    return {vs, hd};
  endfunction

  initial begin
    int firstValid;
    int busyCount;
    int errCount;

    // Reset
    applyStimulus(1, 0, 3'b000, 0, 7'd0);
    applyStimulus(1, 0, 3'b000, 0, 7'd0);

    // Continuous strobes at the default depth
    firstValid = -1;
    busyCount  = 0;
    for (int k = 0; k < 80; k++) begin
      applyStimulus(0, 1, rndSync(1'b0), 0, 7'd0);
      if (busy) busyCount++;
      if (o_valid && firstValid < 0) firstValid = k + 1;
    end
    checkOne("first_valid_clk", 32'(firstValid), 32'd57);
    checkOne("busy_clocks",     32'(busyCount),  32'd56);

    // Illegal depth requests, then a frame start: depth stays 56
    errCount = 0;
    applyStimulus(0, 1, rndSync(1'b0), 1, 7'd0);
    if (cfg_err) errCount++;
    applyStimulus(0, 1, rndSync(1'b0), 1, 7'd65);
    if (cfg_err) errCount++;
    applyStimulus(0, 1, rndSync(1'b0), 0, 7'd0);
    if (cfg_err) errCount++;
    checkOne("err_pulses", 32'(errCount), 32'd2);
    applyStimulus(0, 1, rndSync(1'b1), 0, 7'd0);
    for (int k = 0; k < 10; k++) applyStimulus(0, 1, rndSync(1'b0), 0, 7'd0);

    // Depth 8 requested mid-frame, applied at the next frame start
    applyStimulus(0, 1, rndSync(1'b0), 1, 7'd8);
    for (int k = 0; k < 20; k++) applyStimulus(0, 1, rndSync(1'b0), 0, 7'd0);
    applyStimulus(0, 1, rndSync(1'b1), 0, 7'd0);
    for (int k = 0; k < 40; k++) applyStimulus(0, 1, rndSync(1'b0), 0, 7'd0);

    // Alternating strobe
    for (int k = 0; k < 60; k++) applyStimulus(0, (k % 2) == 0, rndSync(1'b0), 0, 7'd0);

    // Full-ring depth 64 across pointer wrap
    applyStimulus(0, 1, rndSync(1'b0), 1, 7'd64);
    applyStimulus(0, 1, rndSync(1'b1), 0, 7'd0);
    for (int k = 0; k < 200; k++) applyStimulus(0, 1, rndSync(1'b0), 0, 7'd0);

    // cfg_wr on a frame-start cycle: takes effect one frame later
    applyStimulus(0, 1, rndSync(1'b0), 0, 7'd0);
    applyStimulus(0, 1, rndSync(1'b1), 1, 7'd20);
    for (int k = 0; k < 30; k++) applyStimulus(0, 1, rndSync(1'b0), 0, 7'd0);
    applyStimulus(0, 1, rndSync(1'b1), 0, 7'd0);
    for (int k = 0; k < 40; k++) applyStimulus(0, 1, rndSync(1'b0), 0, 7'd0);

    // Random strobes, frame starts and depth requests
    for (int k = 0; k < 600; k++) begin
      logic       e, vs, cw;
      logic [6:0] cd;
      e  = ($urandom_range(0, 3) != 0);
      vs = ($urandom_range(0, 39) == 0);
      cw = ($urandom_range(0, 29) == 0);
      cd = 7'($urandom_range(0, 70));
      applyStimulus(0, e, rndSync(vs), cw, cd);
    end

    // Reset in RUN
    for (int k = 0; k < 5; k++) applyStimulus(0, 1, rndSync(1'b0), 0, 7'd0);
    applyStimulus(1, 1, rndSync(1'b0), 0, 7'd0);
    applyStimulus(0, 1, rndSync(1'b0), 0, 7'd0);
    checkOne("busy_after_rst", 32'(busy), 32'd1);
    for (int k = 0; k < 70; k++) applyStimulus(0, 1, rndSync(1'b0), 0, 7'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
